// File: rtl/fetch_stream_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_stream_unit_if
//
// Bundles the two streaming faces of the fetch stage:
//   imem request   : imem_valid / imem_ready / imem_address
//   imem response  : imem_dp_valid / imem_dp_ready / imem_dp_read_data
//   decode window  : f_valid / f_ready / f_bytes_read / f_valid_bytes /
//                    f_instruction / f_pc
//
// Modports:
//   master - the fetch unit (drives requests and the decode window)
//   slave  - the environment (instruction memory plus decode)
// ----------------------------------------------------------------------------
interface fetch_stream_unit_if #(
  parameter int ADDRW        = 32,
  parameter int LINE_BYTES   = 16,
  parameter int WINDOW_BYTES = 32
);
  localparam int FVBW = $clog2(WINDOW_BYTES + 1);

  logic                      imem_valid;
  logic                      imem_ready;
  logic [ADDRW-1:0]          imem_address;
  logic                      imem_dp_valid;
  logic                      imem_dp_ready;
  logic [8*LINE_BYTES-1:0]   imem_dp_read_data;
  logic                      f_valid;
  logic                      f_ready;
  logic [FVBW-1:0]           f_bytes_read;
  logic [FVBW-1:0]           f_valid_bytes;
  logic [8*WINDOW_BYTES-1:0] f_instruction;
  logic [ADDRW-1:0]          f_pc;

  modport master (
    output imem_valid, imem_address, imem_dp_ready,
    output f_valid, f_valid_bytes, f_instruction, f_pc,
    input  imem_ready, imem_dp_valid, imem_dp_read_data,
    input  f_ready, f_bytes_read
  );

  modport slave (
    input  imem_valid, imem_address, imem_dp_ready,
    input  f_valid, f_valid_bytes, f_instruction, f_pc,
    output imem_ready, imem_dp_valid, imem_dp_read_data,
    output f_ready, f_bytes_read
  );
endinterface

// File: rtl/fetch_stream_unit.sv
// ----------------------------------------------------------------------------
// fetch_stream_unit
//
// Fetch stage between the instruction memory port and decode. Issues
// line-aligned requests (up to MAX_OUT in flight), buffers returned lines in a
// DEPTH-entry queue and presents decode with a byte-aligned window of up to
// WINDOW_BYTES bytes starting at f_pc. After every redirect (load) all
// responses still in flight are counted and discarded.
//
// Ports:
//   clk          - clock
//   reset        - synchronous active-high reset
//   load         - redirect strobe, also flushes the queue
//   load_address - linear redirect target
//   bus          - fetch_stream_unit_if.master (imem request/response and
//                  decode window signals)
//
// Optional build macro FETCH_PERF_EN adds three saturating 32-bit counters:
//   perf_starve_cycles - cycles streaming with no valid window
//   perf_dropped_lines - stale responses discarded after redirects
//   perf_full_cycles   - cycles where issue is blocked by DEPTH/MAX_OUT
// ----------------------------------------------------------------------------
module fetch_stream_unit #(
  parameter int ADDRW        = 32,
  parameter int LINE_BYTES   = 16,
  parameter int DEPTH        = 4,
  parameter int MAX_OUT      = 2,
  parameter int WINDOW_BYTES = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [ADDRW-1:0]       load_address,
  fetch_stream_unit_if.master    bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_starve_cycles,
  output logic [31:0]            perf_dropped_lines,
  output logic [31:0]            perf_full_cycles
`endif
);

  localparam int LINE_W     = $clog2(LINE_BYTES);
  localparam int PTRW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW       = $clog2(DEPTH + 1);
  localparam int OUTW       = $clog2(MAX_OUT + 1);
  localparam int FVBW       = $clog2(WINDOW_BYTES + 1);
  // Byte-count arithmetic width: holds head_off + a full window.
  localparam int BW         = CNTW + LINE_W + 1;
  localparam int LINE_BITS  = 8 * LINE_BYTES;
  localparam int WIN_BITS   = 8 * WINDOW_BYTES;
  // A window that starts mid-line touches one more line than it covers.
  localparam int SPAN_LINES = WINDOW_BYTES / LINE_BYTES + 1;
  localparam int SPAN_BITS  = SPAN_LINES * LINE_BITS;

  localparam logic [CNTW:0]      DEPTH_V   = (CNTW + 1)'(DEPTH);
  localparam logic [OUTW-1:0]    MAX_OUT_V = OUTW'(MAX_OUT);
  localparam logic [BW-1:0]      WIN_V     = BW'(WINDOW_BYTES);
  localparam logic [ADDRW-1:0]   LINE_STEP = ADDRW'(LINE_BYTES);
  localparam logic [ADDRW-1:0]   LINE_MASK = ADDRW'(LINE_BYTES - 1);
  localparam logic [PTRW-1:0]    PTR_MASK  = PTRW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t state_reg, state_next;

  logic [ADDRW-1:0]  fetch_addr_reg;
  logic [LINE_W-1:0] head_off_reg;
  logic [ADDRW-1:0]  f_pc_reg;
  logic [PTRW-1:0]   rd_ptr_reg;
  logic [PTRW-1:0]   wr_ptr_reg;
  logic [CNTW-1:0]   occ_reg;
  logic [OUTW-1:0]   out_reg;
  logic [OUTW-1:0]   drop_reg;

  // Flop-based line buffer: the window reads several entries at once and
  // a pushed line must be visible on the very next cycle.
  logic [LINE_BITS-1:0] line_mem [DEPTH];

  logic            issue_space;
  logic            req_acc;
  logic            resp;
  logic            drop_now;
  logic            push;
  logic            consume;
  logic [CNTW:0]   inflight;
  logic [OUTW-1:0] out_next;
  logic [BW-1:0]   occ_bytes;
  logic [BW-1:0]   avail;
  logic [BW-1:0]   win_bytes;
  logic [BW-1:0]   n_bytes;
  logic [BW-1:0]   new_head;
  logic [CNTW-1:0] pops;
  logic [SPAN_BITS-1:0] span_data;

  // --------------------------------------------------------------------------
  // Issue / response bookkeeping
  // --------------------------------------------------------------------------
  // Queue space is reserved at issue time, so a response can always be taken.
  assign inflight    = (CNTW + 1)'(out_reg) + (CNTW + 1)'(occ_reg);
  assign issue_space = (inflight < DEPTH_V) && (out_reg < MAX_OUT_V);
  assign req_acc     = bus.imem_valid && bus.imem_ready;
  assign resp        = bus.imem_dp_valid;
  assign drop_now    = resp && (drop_reg != '0);
  assign push        = resp && !drop_now && !load && !reset;
  assign out_next    = out_reg + OUTW'(req_acc) - OUTW'(resp);

  assign bus.imem_address  = fetch_addr_reg;
  assign bus.imem_dp_ready = 1'b1;

  // --------------------------------------------------------------------------
  // FSM: IDLE until the first redirect, then STREAM forever (until reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bus.imem_valid = 1'b0;
    if (load) begin
      state_next = S_STREAM;
    end
    if (state_reg == S_STREAM && !load && issue_space) begin
      bus.imem_valid = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Decode window
  // --------------------------------------------------------------------------
  // head_off may be non-zero with an empty queue right after a redirect.
  assign occ_bytes = BW'({occ_reg, {LINE_W{1'b0}}});
  assign avail     = (occ_reg == '0) ? '0 : (occ_bytes - BW'(head_off_reg));
  assign win_bytes = (avail > WIN_V) ? WIN_V : avail;

  assign bus.f_valid_bytes = FVBW'(win_bytes);
  assign bus.f_valid       = (win_bytes != '0) && !load;
  assign bus.f_pc          = f_pc_reg;

  assign consume  = bus.f_valid && bus.f_ready;
  assign n_bytes  = (BW'(bus.f_bytes_read) > win_bytes) ? win_bytes
                                                        : BW'(bus.f_bytes_read);
  assign new_head = BW'(head_off_reg) + n_bytes;
  assign pops     = CNTW'(new_head >> LINE_W);

  // Gather the lines starting at the read pointer; entries past occupancy
  // only feed don't-care bytes beyond f_valid_bytes.
  generate
    for (genvar gi = 0; gi < SPAN_LINES; gi++) begin : g_span
      logic [PTRW-1:0] idx;
      assign idx = (rd_ptr_reg + PTRW'(gi)) & PTR_MASK;
      assign span_data[gi*LINE_BITS +: LINE_BITS] = line_mem[idx];
    end
  endgenerate

  assign bus.f_instruction = WIN_BITS'(span_data >> {head_off_reg, 3'b000});

  // --------------------------------------------------------------------------
  // Line storage (no reset needed: occupancy gates all visible bytes)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      line_mem[wr_ptr_reg] <= bus.imem_dp_read_data;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr_reg <= '0;
      head_off_reg   <= '0;
      f_pc_reg       <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      occ_reg        <= '0;
      out_reg        <= '0;
      drop_reg       <= '0;
    end else if (load) begin
      fetch_addr_reg <= load_address & ~LINE_MASK;
      head_off_reg   <= load_address[LINE_W-1:0];
      f_pc_reg       <= load_address;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      occ_reg        <= '0;
      out_reg        <= out_next;
      // Everything still in flight after this cycle belongs to the old
      // stream, including a response arriving right now (flushed anyway).
      drop_reg       <= out_next;
    end else begin
      out_reg <= out_next;
      if (req_acc) begin
        fetch_addr_reg <= fetch_addr_reg + LINE_STEP;
      end
      if (drop_now) begin
        drop_reg <= drop_reg - 1'b1;
      end
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg + 1'b1) & PTR_MASK;
      end
      if (consume) begin
        head_off_reg <= new_head[LINE_W-1:0];
        f_pc_reg     <= f_pc_reg + ADDRW'(n_bytes);
        rd_ptr_reg   <= (rd_ptr_reg + PTRW'(pops)) & PTR_MASK;
      end
      occ_reg <= occ_reg + CNTW'(push) - (consume ? pops : '0);
    end
  end

`ifdef FETCH_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0] starve_cnt_reg;
  logic [31:0] dropped_cnt_reg;
  logic [31:0] full_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg  <= '0;
      dropped_cnt_reg <= '0;
      full_cnt_reg    <= '0;
    end else begin
      if (state_reg == S_STREAM && !bus.f_valid && starve_cnt_reg != '1) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
      if (drop_now && dropped_cnt_reg != '1) begin
        dropped_cnt_reg <= dropped_cnt_reg + 1'b1;
      end
      if (state_reg == S_STREAM && !load && !issue_space && full_cnt_reg != '1) begin
        full_cnt_reg <= full_cnt_reg + 1'b1;
      end
    end
  end

  assign perf_starve_cycles = starve_cnt_reg;
  assign perf_dropped_lines = dropped_cnt_reg;
  assign perf_full_cycles   = full_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stream_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_stream_unit
//
// Directed bench for fetch_stream_unit. A small instruction memory model
// returns lines in order after a programmable latency; byte at address x is
// x[7:0] ^ x[15:8], so every window byte identifies its source address.
// Define FETCH_PERF_EN to also check the performance counters.
// ----------------------------------------------------------------------------
module tb_fetch_stream_unit;

  localparam int ADDRW        = 32;
  localparam int LINE_BYTES   = 16;
  localparam int DEPTH        = 4;
  localparam int MAX_OUT      = 2;
  localparam int WINDOW_BYTES = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [ADDRW-1:0] load_address;

  always #5 clk = ~clk;

  fetch_stream_unit_if #(
    .ADDRW(ADDRW), .LINE_BYTES(LINE_BYTES), .WINDOW_BYTES(WINDOW_BYTES)
  ) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_starve_cycles;
  logic [31:0] perf_dropped_lines;
  logic [31:0] perf_full_cycles;
`endif

  fetch_stream_unit #(
    .ADDRW(ADDRW), .LINE_BYTES(LINE_BYTES), .DEPTH(DEPTH),
    .MAX_OUT(MAX_OUT), .WINDOW_BYTES(WINDOW_BYTES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_address(load_address),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_starve_cycles(perf_starve_cycles),
    .perf_dropped_lines(perf_dropped_lines),
    .perf_full_cycles(perf_full_cycles)
`endif
  );

  // --------------------------------------------------------------------------
  // Memory model
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  int          cyc_cnt = 0;
  int          lat = 1;

  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [127:0] d;
    logic [31:0]  x;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      x = a + 32'(i);
      d[i*8 +: 8] = x[7:0] ^ x[15:8];
    end
    return d;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pend_q.delete();
    end else begin
      if (bus.imem_dp_valid && pend_q.size() > 0) begin
        void'(pend_q.pop_front());
      end
      if (bus.imem_valid && bus.imem_ready) begin
        pend_q.push_back('{addr: bus.imem_address, due: cyc_cnt + lat});
        req_log.push_back(bus.imem_address);
      end
    end
    cyc_cnt++;
    #1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc_cnt) begin
      bus.imem_dp_valid     = 1'b1;
      bus.imem_dp_read_data = line_data(pend_q[0].addr);
    end else begin
      bus.imem_dp_valid     = 1'b0;
      bus.imem_dp_read_data = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    bus.f_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    req_log.delete();
  endtask

  task automatic do_load(input logic [31:0] a);
    load         = 1'b1;
    load_address = a;
    req_log.delete();
    tick();
    load = 1'b0;
  endtask

  task automatic wait_fvalid(input int budget, input string tag);
    int i;
    i = 0;
    while (!bus.f_valid && i < budget) begin
      tick();
      i++;
    end
    check_eq({tag, "_f_valid"}, 64'(bus.f_valid), 64'd1);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  logic [31:0] t3_pc [4] = '{32'h3000, 32'h3007, 32'h300E, 32'h3015};
  logic [7:0]  t3_b0 [4] = '{8'h30, 8'h37, 8'h3E, 8'h25};
  logic [31:0] t2_req[4] = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};

  initial begin
    int bad;
    int i;
    reset        = 1'b1;
    load         = 1'b0;
    load_address = '0;
    bus.imem_ready   = 1'b1;
    bus.f_ready      = 1'b0;
    bus.f_bytes_read = '0;

    // Reset state and idle behaviour
    do_reset();
    check_eq("rst_imem_valid", 64'(bus.imem_valid), 64'd0);
    check_eq("rst_f_valid", 64'(bus.f_valid), 64'd0);
    check_eq("rst_f_valid_bytes", 64'(bus.f_valid_bytes), 64'd0);
    check_eq("rst_f_pc", 64'(bus.f_pc), 64'd0);
    check_eq("rst_imem_address", 64'(bus.imem_address), 64'd0);
    check_eq("rst_imem_dp_ready", 64'(bus.imem_dp_ready), 64'd1);
`ifdef FETCH_PERF_EN
    check_eq("rst_perf_dropped", 64'(perf_dropped_lines), 64'd0);
`endif
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.imem_valid || bus.f_valid) bad++;
    end
    check_eq("idle_quiet_cycles", 64'(bad), 64'd0);

    // Unaligned redirect, one-cycle memory, decode stalled
    lat = 1;
    do_load(32'h1003);
    wait_fvalid(10, "t2_first");
    check_eq("t2_f_pc", 64'(bus.f_pc), 64'h1003);
    check_eq("t2_fvb_13", 64'(bus.f_valid_bytes), 64'd13);
    check_eq("t2_byte0", 64'(bus.f_instruction[7:0]), 64'h13);
    tick();
    check_eq("t2_fvb_29", 64'(bus.f_valid_bytes), 64'd29);
    tick();
    check_eq("t2_fvb_32", 64'(bus.f_valid_bytes), 64'd32);
    check_eq("t2_byte31", 64'(bus.f_instruction[255:248]), 64'h32);
    repeat (8) tick();
    check_eq("t2_req_count", 64'(req_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t2_req%0d", k), 64'(log_at(k)), 64'(t2_req[k]));
    end
    check_eq("t2_full_no_issue", 64'(bus.imem_valid), 64'd0);

    // 7-byte consumes from 0x3000
    do_load(32'h3000);
    bus.f_bytes_read = 6'd7;
    bus.f_ready      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_fvalid(10, $sformatf("t3_step%0d", k));
      check_eq($sformatf("t3_f_pc%0d", k), 64'(bus.f_pc), 64'(t3_pc[k]));
      check_eq($sformatf("t3_byte0_%0d", k), 64'(bus.f_instruction[7:0]),
               64'(t3_b0[k]));
      tick();
    end
    bus.f_ready = 1'b0;

    // Redirect with two requests in flight, five-cycle memory
    do_reset();
    lat = 5;
    do_load(32'h5000);
    i = 0;
    while (req_log.size() < 2 && i < 10) begin
      tick();
      i++;
    end
    check_eq("t4_two_outstanding", 64'(req_log.size()), 64'd2);
    do_load(32'h2000);
    wait_fvalid(40, "t4_first");
    check_eq("t4_f_pc", 64'(bus.f_pc), 64'h2000);
    check_eq("t4_byte0", 64'(bus.f_instruction[7:0]), 64'h20);
    check_eq("t4_byte15", 64'(bus.f_instruction[127:120]), 64'h2F);
    check_eq("t4_fvb", 64'(bus.f_valid_bytes), 64'd16);
    check_eq("t4_first_req", 64'(log_at(0)), 64'h2000);
`ifdef FETCH_PERF_EN
    check_eq("t4_perf_dropped", 64'(perf_dropped_lines), 64'd2);
`endif

    // Reset in the middle of streaming
    reset = 1'b1;
    tick();
    check_eq("midrst_imem_valid", 64'(bus.imem_valid), 64'd0);
    check_eq("midrst_f_valid", 64'(bus.f_valid), 64'd0);
    check_eq("midrst_f_pc", 64'(bus.f_pc), 64'd0);
    check_eq("midrst_imem_address", 64'(bus.imem_address), 64'd0);
    check_eq("midrst_fvb", 64'(bus.f_valid_bytes), 64'd0);
`ifdef FETCH_PERF_EN
    check_eq("midrst_perf_dropped", 64'(perf_dropped_lines), 64'd0);
    check_eq("midrst_perf_starve", 64'(perf_starve_cycles), 64'd0);
    check_eq("midrst_perf_full", 64'(perf_full_cycles), 64'd0);
`endif
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.imem_valid || bus.f_valid) bad++;
    end
    check_eq("midrst_idle_cycles", 64'(bad), 64'd0);

    // Decode never ready from 0x0: fills exactly DEPTH lines
    lat = 1;
    do_load(32'h0);
    repeat (15) tick();
    check_eq("t6_req_count", 64'(req_log.size()), 64'd4);
    check_eq("t6_imem_valid", 64'(bus.imem_valid), 64'd0);
    check_eq("t6_fvb", 64'(bus.f_valid_bytes), 64'd32);
    check_eq("t6_f_pc", 64'(bus.f_pc), 64'd0);
    check_eq("t6_byte31", 64'(bus.f_instruction[255:248]), 64'h1F);

    // Address wrap at the top of the space
    do_reset();
    lat = 1;
    do_load(32'hFFFF_FFF8);
    wait_fvalid(10, "t7_first");
    check_eq("t7_f_pc", 64'(bus.f_pc), 64'hFFFF_FFF8);
    check_eq("t7_fvb", 64'(bus.f_valid_bytes), 64'd8);
    check_eq("t7_byte0", 64'(bus.f_instruction[7:0]), 64'h07);
    bus.f_bytes_read = 6'd8;
    bus.f_ready      = 1'b1;
    tick();
    bus.f_ready      = 1'b0;
    wait_fvalid(10, "t7_wrap");
    check_eq("t7_f_pc_wrapped", 64'(bus.f_pc), 64'd0);
    check_eq("t7_byte0_wrapped", 64'(bus.f_instruction[7:0]), 64'h00);
    check_eq("t7_req0", 64'(log_at(0)), 64'hFFFF_FFF0);
    check_eq("t7_req1", 64'(log_at(1)), 64'h0000_0000);
    repeat (10) tick();
    check_eq("t7_req_count", 64'(req_log.size()), 64'd5);
    check_eq("t7_fvb_full", 64'(bus.f_valid_bytes), 64'd32);

    // Over-long consume is clamped to the valid bytes
    bus.f_bytes_read = 6'd40;
    bus.f_ready      = 1'b1;
    tick();
    bus.f_ready      = 1'b0;
    check_eq("clamp_f_pc", 64'(bus.f_pc), 64'h20);
    check_eq("clamp_byte0", 64'(bus.f_instruction[7:0]), 64'h20);
    check_eq("clamp_fvb", 64'(bus.f_valid_bytes), 64'd32);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
